// File: rtl/seq_mult.sv
// Iterative shift-add unsigned multiplier with start/done handshake.
// Define SEQ_MULT_EARLY_EXIT_EN to leave RUN as soon as the remaining multiplier bits are zero.
module seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     result,
  output logic                 overflow
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier_sh;
  logic             last;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
    mplier_sh = mplier_q >> 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    last = (cnt_q == CW'(WIDTH - 1)) || (mplier_sh == '0);
`else
    last = (cnt_q == CW'(WIDTH - 1));
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = PW'(a);
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          // Product includes this edge's partial-product addition
          state_d    = DONE;
          done_d     = 1'b1;
          product_d  = acc_sum;
          overflow_d = |acc_sum[PW-1:WIDTH];
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign product  = product_q;
  assign result   = product_q[WIDTH-1:0];
  assign overflow = overflow_q;

endmodule

// File: doc/seq_mult.md
# seq_mult

Iterative shift-add unsigned multiplier, parametrised in operand width, with a start/done handshake and an overflow flag. It produces the full 2×WIDTH product plus a truncated WIDTH-bit result, so it serves both full-precision and ALU-width consumers. It is the multi-cycle successor to the combinational 8-bit ALU multiplier and sits beside the adder in the ALU datapath, trading latency for area.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a multiply; sampled on the rising edge of clk.
- a  in  WIDTH  multiplicand; captured on an accepted start.
- b  in  WIDTH  multiplier; captured on an accepted start.
- busy  out  1  high while an operation is in progress (RUN state).
- done  out  1  one-cycle pulse; product, result and overflow are valid from this cycle.
- product  out  2×WIDTH  full unsigned product a×b.
- result  out  WIDTH  product[WIDTH-1:0].
- overflow  out  1  high when product[2×WIDTH-1:WIDTH] ≠ 0.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - mcand, 2×WIDTH bits.
  - mplier, WIDTH bits.
  - acc, 2×WIDTH bits.
  - cnt, ⌈log2 WIDTH⌉ bits.
- **Accepting start:** start is accepted in IDLE or DONE. On acceptance:
  - mcand ← zero-extended a; mplier ← b; acc ← 0; cnt ← 0.
  - Next state is RUN.
- **start in RUN** is ignored and has no effect on the operation in flight.
- **RUN, each edge:**
  - If mplier[0] = 1: acc ← acc + mcand.
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt + 1.
- **Leaving RUN:** on the edge where cnt = WIDTH-1 (or the early-exit condition under Configuration holds):
  - Next state is DONE.
  - product ← final acc, including that edge's addition.
  - overflow ← OR-reduce of the upper half of the final acc.
- **DONE:** lasts one cycle. Without an accepted start, next state is IDLE.
- **Output registers:**
  - product, result and overflow change only on entry to DONE.
  - They hold their value through IDLE and through any following RUN until the next DONE.
- **Arithmetic:** unsigned only; acc is 2×WIDTH bits and cannot wrap.
- **Reset**, asserted at any time including mid-operation:
  - State goes to IDLE.
  - busy = 0, done = 0, product = 0, result = 0, overflow = 0; all internal registers cleared.
  - An operation in progress is abandoned. No done is produced for it.

## Timing
- Start accepted at edge k:
  - busy = 1 from edge k until the edge that enters DONE.
  - done = 1 for exactly the one cycle following edge k+WIDTH; latency is WIDTH cycles.
- busy and done are never high together.
- **Back-to-back:** start high during the DONE cycle is accepted. RUN resumes on the next edge, and the previous product stays on the outputs until the new DONE.
- **Registered outputs:** busy, done, product, result and overflow are driven from flops only, with no combinational path from start, a or b.

## Configuration
- **SEQ_MULT_EARLY_EXIT_EN defined:** RUN also exits to DONE when the mplier value after the current edge's shift is 0.
  - Latency becomes max(1, p+1) cycles, where p is the index of the most-significant set bit of b.
  - b = 0 gives 1 cycle.
  - product and overflow values are identical to the undefined case.
- **SEQ_MULT_EARLY_EXIT_EN undefined:** latency is fixed at WIDTH cycles for all operands.

## Test plan
WIDTH = 8 unless stated.
- Reset behaviour -> all outputs 0 after reset.
- a=15, b=17 -> product 0x00FF, result 0xFF, overflow 0, done 8 cycles after start, busy high for those 8 cycles.
- a=16, b=16 -> product 0x0100, result 0x00, overflow 1. a=255, b=255 -> product 0xFE01, overflow 1.
- start re-asserted with a=3, b=3 during RUN of 5×7 -> ignored; product 35 (0x0023) on done. Then start a=3, b=3 held high in the DONE cycle -> accepted; the next done gives product 9, and product holds 35 in between.
- rst_n pulsed low at cycle 4 of a 200×200 multiply -> outputs 0, state IDLE, no done. A fresh 2×3 -> product 6.
- With SEQ_MULT_EARLY_EXIT_EN: a=200, b=3 -> done after 2 cycles, product 600; b=0 -> done after 1 cycle, product 0. Without the macro: both cases take 8 cycles and give the same values.
- WIDTH = 16: a=0xFFFF, b=0xFFFF -> product 0xFFFE0001, overflow 1, latency 16 cycles.
